// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM encoding and helpers for the 5x5 window address generator
//
// Purpose: kernel geometry, buffer address width, FSM state encoding and the
//          output-dimension helper used by the window address generator.
// Ports:   none (package)

package conv_pkg;

  localparam int KSIZE  = 5;
  localparam int NTAP   = KSIZE * KSIZE;
  localparam int BUF_AW = 11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_BUF = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Number of window positions along one axis.
  function automatic int out_dim(input int in_dim, input int k, input int stride);
    return (in_dim - k) / stride + 1;
  endfunction

endpackage

// File: rtl/win_pos_counter.sv
// rtl/win_pos_counter.sv - output-pixel position counter with incremental window base address
//
// Purpose: tracks the current output pixel (ox, oy) and the buffer address of
//          its window's top-left tap, stepping in raster order on advance.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   clear     in   return to window (0,0)
//   advance   in   step to the next window in raster order
//   ox, oy    out  current output-pixel position
//   win_base  out  address of tap (0,0) of the current window
//   last_win  out  current window is the final one of the frame

module win_pos_counter
  import conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [7:0]        ox,
  output logic [7:0]        oy,
  output logic [BUF_AW-1:0] win_base,
  output logic              last_win
);

  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);

  localparam logic [BUF_AW-1:0] ROW_STEP = BUF_AW'(STRIDE * IMG_W);
  localparam logic [BUF_AW-1:0] COL_STEP = BUF_AW'(STRIDE);

  logic [BUF_AW-1:0] row_base;
  logic [BUF_AW-1:0] col_off;
  logic              last_col;

  assign last_col = (ox == 8'(OW - 1));
  assign last_win = last_col && (oy == 8'(OH - 1));

  // Both offsets are accumulated so no multiplier is needed for ox*STRIDE or oy*STRIDE*IMG_W.
  assign win_base = row_base + col_off;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ox       <= '0;
      oy       <= '0;
      row_base <= '0;
      col_off  <= '0;
    end else if (advance) begin
      if (last_col) begin
        ox       <= '0;
        col_off  <= '0;
        oy       <= oy + 8'd1;
        row_base <= row_base + ROW_STEP;
      end else begin
        ox      <= ox + 8'd1;
        col_off <= col_off + COL_STEP;
      end
    end
  end

endmodule

// File: rtl/conv5x5_window_addr_gen.sv
// rtl/conv5x5_window_addr_gen.sv - read-side 25-tap address generator sweeping a 5x5 window over one frame
//
// Purpose: walks a 5x5 window over an IMG_W x IMG_H feature map and presents all
//          25 tap addresses per output pixel with a valid/ready handshake.
// Ports:
//   clk             in   system clock
//   rst             in   synchronous reset, active-high
//   start           in   request one frame; only honoured in IDLE
//   frame_ready     in   readable bank holds a complete frame
//   out_ready       in   downstream accepts the current window
//   rd_addr_25P     out  tap j = ky*5+kx in slot [ADDR_W*j +: ADDR_W]
//   addr_valid      out  rd_addr_25P holds a valid window
//   out_col         out  output-pixel x of the current window
//   out_row         out  output-pixel y of the current window
//   busy            out  high in every state except IDLE
//   done            out  1-cycle pulse after the last window handshake
//   frame_consumed  out  1-cycle pulse, coincident with done

module conv5x5_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 frame_ready,
  input  logic                 out_ready,
  output logic [ADDR_W*25-1:0] rd_addr_25P,
  output logic                 addr_valid,
  output logic [7:0]           out_col,
  output logic [7:0]           out_row,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_consumed
);

  logic [1:0]        state;
  logic              handshake;
  logic              advance;
  logic              clear;
  logic              last_win;
  logic [BUF_AW-1:0] win_base;

  assign handshake = addr_valid & out_ready;
  // The last window is not advanced past; the counter is cleared back in IDLE instead.
  assign advance   = (state == ST_RUN) & handshake & ~last_win;
  assign clear     = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  win_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .ox       (out_col),
    .oy       (out_row),
    .win_base (win_base),
    .last_win (last_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      addr_valid     <= 1'b0;
      done           <= 1'b0;
      frame_consumed <= 1'b0;
    end else begin
      done           <= 1'b0;
      frame_consumed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_WAIT_BUF;
        end
        ST_WAIT_BUF: begin
          // Counter was held at (0,0) in IDLE, so window 0 is already on the address bus.
          if (frame_ready) begin
            state      <= ST_RUN;
            addr_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (handshake && last_win) begin
            state          <= ST_DONE;
            addr_valid     <= 1'b0;
            done           <= 1'b1;
            frame_consumed <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-tap offsets ky*IMG_W+kx are fixed at elaboration; addresses are masked while invalid.
  for (genvar j = 0; j < NTAP; j++) begin : g_tap
    localparam logic [BUF_AW-1:0] TAP_OFF = BUF_AW'((j / KSIZE) * IMG_W + (j % KSIZE));
    logic [BUF_AW-1:0] tap;
    assign tap = win_base + TAP_OFF;
    assign rd_addr_25P[ADDR_W*j +: ADDR_W] = addr_valid ? ADDR_W'(tap) : '0;
  end

endmodule

// File: tb/tb_conv5x5_window_addr_gen.sv
// tb/tb_conv5x5_window_addr_gen.sv - randomized model-checked bench for the 5x5 window address generator

module tb_conv5x5_window_addr_gen;

  logic clk = 1'b0;
  logic rst, start, frame_ready, out_ready;

  logic [799:0] rd0, rd1;
  logic         valid0, valid1, busy0, busy1, done0, done1, fc0, fc1;
  logic [7:0]   col0, col1, row0, row1;

  always #5 clk = ~clk;

  conv5x5_window_addr_gen #(.IMG_W(32), .IMG_H(32), .K(5), .STRIDE(1), .ADDR_W(32)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .frame_ready(frame_ready), .out_ready(out_ready),
    .rd_addr_25P(rd0), .addr_valid(valid0), .out_col(col0), .out_row(row0),
    .busy(busy0), .done(done0), .frame_consumed(fc0)
  );

  conv5x5_window_addr_gen #(.IMG_W(32), .IMG_H(32), .K(5), .STRIDE(2), .ADDR_W(32)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .frame_ready(frame_ready), .out_ready(out_ready),
    .rd_addr_25P(rd1), .addr_valid(valid1), .out_col(col1), .out_row(row1),
    .busy(busy1), .done(done1), .frame_consumed(fc1)
  );

  logic [799:0] rd_a    [2];
  logic         valid_a [2];
  logic         busy_a  [2];
  logic         done_a  [2];
  logic         fc_a    [2];
  logic [7:0]   col_a   [2];
  logic [7:0]   row_a   [2];

  assign rd_a[0] = rd0;       assign rd_a[1] = rd1;
  assign valid_a[0] = valid0; assign valid_a[1] = valid1;
  assign busy_a[0] = busy0;   assign busy_a[1] = busy1;
  assign done_a[0] = done0;   assign done_a[1] = done1;
  assign fc_a[0] = fc0;       assign fc_a[1] = fc1;
  assign col_a[0] = col0;     assign col_a[1] = col1;
  assign row_a[0] = row0;     assign row_a[1] = row1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  // Geometry of instance i: stride i+1 on a 32x32 map.
  function automatic int ow_of(input int i);
    return (32 - 5) / (i + 1) + 1;
  endfunction

  function automatic int exp_tap(input int i, input int w, input int j);
    int s, ox, oy;
    s  = i + 1;
    ox = w % ow_of(i);
    oy = w / ow_of(i);
    return (oy * s + j / 5) * 32 + ox * s + (j % 5);
  endfunction

  // Hand-computed pins: {instance, window, tap, address}
  int pins [13][4] = '{
    '{0, 0, 0, 0},   '{0, 0, 4, 4},     '{0, 0, 5, 32},  '{0, 0, 24, 132},
    '{0, 1, 0, 1},   '{0, 1, 24, 133},  '{0, 28, 0, 32}, '{0, 28, 24, 164},
    '{0, 783, 0, 891}, '{0, 783, 24, 1023},
    '{1, 1, 0, 2},   '{1, 14, 0, 64},   '{1, 195, 24, 990}
  };

  // Behavioural model: phase 0 idle, 1 waiting for buffer, 2 presenting window m_w, 3 done pulse.
  int m_phase [2];
  int m_w     [2];
  bit m_init = 1'b0;
  int dut_hs  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] = 0;
        m_w[i]     = 0;
      end else begin
        case (m_phase[i])
          0: if (start) begin m_phase[i] = 1; m_w[i] = 0; end
          1: if (frame_ready) m_phase[i] = 2;
          2: if (out_ready) begin
               if (m_w[i] == ow_of(i) * ow_of(i) - 1) m_phase[i] = 3;
               else m_w[i] = m_w[i] + 1;
             end
          default: m_phase[i] = 0;
        endcase
      end
      // Handshakes actually observed on the DUT in the current frame.
      if (rst || done_a[i] === 1'b1) dut_hs[i] = 0;
      else if (valid_a[i] === 1'b1 && out_ready) dut_hs[i] = dut_hs[i] + 1;
    end
    if (rst) m_init = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy_a[i]), 32'(m_phase[i] != 0));
        chk("addr_valid", i, 32'(valid_a[i]), 32'(m_phase[i] == 2));
        chk("done", i, 32'(done_a[i]), 32'(m_phase[i] == 3));
        chk("frame_consumed", i, 32'(fc_a[i]), 32'(m_phase[i] == 3));
        if (m_phase[i] == 2) begin
          chk("out_col", i, 32'(col_a[i]), m_w[i] % ow_of(i));
          chk("out_row", i, 32'(row_a[i]), m_w[i] / ow_of(i));
          for (int j = 0; j < 25; j++)
            chk("tap", i, rd_a[i][32*j +: 32], exp_tap(i, m_w[i], j));
          for (int p = 0; p < 13; p++)
            if (pins[p][0] == i && pins[p][1] == m_w[i])
              chk("pin_tap", i, rd_a[i][32*pins[p][2] +: 32], pins[p][3]);
        end
        if (done_a[i] === 1'b1)
          chk("handshakes", i, dut_hs[i], ow_of(i) * ow_of(i));
      end
    end
  end

  // mode 0: out_ready high with a 3-cycle stall at window 10
  // mode 1: random out_ready/frame_ready, second start at window 5
  // mode 2: random out_ready, rst asserted at window 400
  task automatic run_frame(input int mode, input int budget);
    bit finished = 1'b0;
    bit event_done = 1'b0;
    int stall_left = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0 === 1'b1) begin finished = 1'b1; break; end
      if (mode == 0) begin
        if (m_phase[0] == 2 && m_w[0] == 10 && !event_done) begin
          event_done = 1'b1;
          stall_left = 3;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        out_ready = ($urandom_range(3) != 0);
        if (m_phase[0] == 2) frame_ready = $urandom_range(1);
        if (mode == 1 && m_phase[0] == 2 && m_w[0] == 5 && !event_done) begin
          event_done = 1'b1;
          start = 1'b1;
        end
        if (mode == 2 && m_phase[0] == 2 && m_w[0] == 400) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("mid_rst_valid", 0, 32'(valid0), 0);
          chk("mid_rst_busy", 0, 32'(busy0), 0);
          chk("mid_rst_col", 0, 32'(col0), 0);
          finished = 1'b1;
          break;
        end
      end
    end
    frame_ready = 1'b1;
    out_ready = 1'b1;
    start = 1'b0;
    if (!finished) chk("frame_timeout", mode, 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr_zero", 0, 32'(|rd0), 0);
    chk("rst_addr_zero", 1, 32'(|rd1), 0);
    chk("rst_col", 0, 32'(col0), 0);
    chk("rst_row", 0, 32'(row0), 0);
    chk("rst_busy", 1, 32'(busy1), 0);
    rst = 1'b0;

    // Latency and full frame with backpressure at window 10
    frame_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("lat_not_yet_valid", 0, 32'(valid0), 0);
    chk("lat_busy", 0, 32'(busy0), 1);
    @(negedge clk);
    chk("lat_valid", 0, 32'(valid0), 1);
    run_frame(0, 3000);
    repeat (3) @(negedge clk);
    chk("idle_after_done", 0, 32'(busy0), 0);

    // Buffer not ready for 5 cycles, then random traffic with a second start in RUN
    frame_ready = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("wait_busy", 0, 32'(busy0), 1);
      chk("wait_no_valid", 0, 32'(valid0), 0);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    chk("ready_valid", 0, 32'(valid0), 1);
    run_frame(1, 4000);
    repeat (3) @(negedge clk);

    // Reset mid-frame, then a fresh frame restarting at window 0
    start = 1'b1;
    run_frame(2, 4000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("restart_tap0", 0, rd0[31:0], 0);
    run_frame(1, 4000);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
